// File: rtl/nlin_f_arbiter.sv
// Round-robin arbiter with packet lock feeding one shared fixed-latency nonlinear unit.
// Optional tag/valid consistency check: define NLIN_F_ARB_ERR_CHK_EN.
module nlin_f_arbiter #(
  parameter int N_LANES  = 4,
  parameter int WORD_WDT = 16,
  parameter int UNIT_LAT = 5,
  localparam int TAG_WDT = (N_LANES > 1) ? $clog2(N_LANES) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_LANES-1:0]            req_val,
  input  logic [N_LANES-1:0]            req_last,
  input  logic [N_LANES*WORD_WDT-1:0]   req_data,
  output logic [N_LANES-1:0]            req_rdy,
  output logic                          unit_clk_en,
  output logic                          unit_op_val,
  output logic [WORD_WDT-1:0]           unit_op_data,
  input  logic                          unit_res_val,
  input  logic [WORD_WDT-1:0]           unit_res_data,
  output logic [N_LANES-1:0]            res_val,
  output logic [WORD_WDT-1:0]           res_data,
  input  logic [N_LANES-1:0]            res_rdy,
  output logic                          busy,
  output logic                          err
);

  // The op register {unit_op_val, op_tag} is the first tag stage; the result
  // appears UNIT_LAT enabled cycles after the unit samples it, hence UNIT_LAT+1 more.
  localparam int TAG_STAGES = UNIT_LAT + 1;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t               state, state_nxt;
  logic [TAG_WDT-1:0]   ptr, ptr_nxt, lock_lane, lock_nxt;
  logic [TAG_WDT-1:0]   rr_lane, cand, sel, op_tag;
  logic                 rr_hit, sel_en, accept;
  logic [TAG_STAGES-1:0] tag_val;
  logic [TAG_WDT-1:0]   tag_id [TAG_STAGES];
  logic                 hv;
  logic [TAG_WDT-1:0]   ht;

  assign hv          = tag_val[TAG_STAGES-1];
  assign ht          = tag_id[TAG_STAGES-1];
  assign unit_clk_en = !(hv && unit_res_val && !res_rdy[ht]);
  assign res_data    = unit_res_data;
  assign busy        = (|tag_val) || (state != IDLE) || unit_op_val;

  always_comb begin
    res_val = '0;
    if (hv && unit_res_val) res_val[ht] = 1'b1;
  end

  // Search starts just after the last winner; the modulo keeps unused tag codes out.
  always_comb begin
    rr_hit  = 1'b0;
    rr_lane = '0;
    cand    = '0;
    for (int k = 1; k <= N_LANES; k++) begin
      cand = TAG_WDT'((int'(ptr) + k) % N_LANES);
      if (!rr_hit && req_val[cand]) begin
        rr_hit  = 1'b1;
        rr_lane = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    lock_nxt  = lock_lane;
    req_rdy   = '0;
    sel       = (state == LOCK) ? lock_lane : rr_lane;
    sel_en    = (state == LOCK) || rr_hit;
    if (sel_en) req_rdy[sel] = unit_clk_en;
    accept    = sel_en && unit_clk_en && req_val[sel];
    if (accept) begin
      ptr_nxt   = sel;
      lock_nxt  = sel;
      state_nxt = req_last[sel] ? IDLE : LOCK;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= TAG_WDT'(N_LANES - 1);
      lock_lane <= '0;
    end else if (unit_clk_en) begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      lock_lane <= lock_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      unit_op_val  <= 1'b0;
      unit_op_data <= '0;
      op_tag       <= '0;
      tag_val      <= '0;
      for (int i = 0; i < TAG_STAGES; i++) tag_id[i] <= '0;
    end else if (unit_clk_en) begin
      unit_op_val <= accept;
      if (accept) begin
        unit_op_data <= req_data[int'(sel)*WORD_WDT +: WORD_WDT];
        op_tag       <= sel;
      end
      tag_val   <= {tag_val[TAG_STAGES-2:0], unit_op_val};
      tag_id[0] <= op_tag;
      for (int i = 1; i < TAG_STAGES; i++) tag_id[i] <= tag_id[i-1];
    end
  end

`ifdef NLIN_F_ARB_ERR_CHK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (unit_clk_en && (unit_res_val != hv)) begin
      err <= 1'b1;
      $error("nlin_f_arbiter: unit_res_val=%0b but head tag valid=%0b", unit_res_val, hv);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_nlin_f_arbiter.sv
// Self-checking bench for nlin_f_arbiter: a behavioural unit model plus an
// arbitration/ordering scoreboard, directed scenarios and a randomized run.
module tb_nlin_f_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 5;
`ifdef NLIN_F_ARB_ERR_CHK_EN
  localparam bit ERR_EXP = 1'b1;
`else
  localparam bit ERR_EXP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_val, req_last, req_rdy, res_val, res_rdy;
  logic [N*W-1:0] req_data;
  logic           unit_clk_en, unit_op_val, unit_res_val, busy, err;
  logic [W-1:0]   unit_op_data, unit_res_data, res_data;
  logic           inj;

  nlin_f_arbiter #(.N_LANES(N), .WORD_WDT(W), .UNIT_LAT(L)) dut (
    .clk(clk), .rst(rst), .req_val(req_val), .req_last(req_last), .req_data(req_data),
    .req_rdy(req_rdy), .unit_clk_en(unit_clk_en), .unit_op_val(unit_op_val),
    .unit_op_data(unit_op_data), .unit_res_val(unit_res_val), .unit_res_data(unit_res_data),
    .res_val(res_val), .res_data(res_data), .res_rdy(res_rdy), .busy(busy), .err(err));

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fn(input logic [W-1:0] x);
    return {x[7:0], x[15:8]} ^ 16'h5A3C;
  endfunction

  // Nonlinear unit model: samples the op on an enabled edge, result L enabled edges later.
  logic [L:0]   u_v;
  logic [W-1:0] u_d [L+1];
  always @(posedge clk) begin
    if (rst) u_v <= '0;
    else if (unit_clk_en) begin
      u_v    <= {u_v[L-1:0], unit_op_val};
      u_d[0] <= fn(unit_op_data);
      for (int i = 1; i <= L; i++) u_d[i] <= u_d[i-1];
    end
  end
  assign unit_res_val  = u_v[L] | inj;
  assign unit_res_data = u_d[L];

  // Scoreboard: accepted beats and delivered results, logged at the falling edge.
  typedef struct { int cyc; int lane; logic [W-1:0] data; } beat_t;
  beat_t exp_q[$];
  beat_t got_q[$];
  int cyc = 0, arb_bad = 0, oh_bad = 0;
  int n_checks = 0, n_fail = 0;
  bit m_lock = 1'b0;
  int m_lane = 0, m_last = N - 1;
  logic [N-1:0] exp_rdy;
  logic m_stall;

  function automatic int lane_of(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference arbitration: locked lane only, else first requester after the last winner.
  always_comb begin
    exp_rdy = '0;
    m_stall = (res_val != 0) && ((res_val & res_rdy) == 0);
    if (!rst && !m_stall) begin
      if (m_lock) exp_rdy[m_lane] = 1'b1;
      else
        for (int k = 1; k <= N; k++)
          if (exp_rdy == 0 && req_val[(m_last + k) % N]) exp_rdy[(m_last + k) % N] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      m_lock <= 1'b0; m_last <= N - 1; m_lane <= 0;
      exp_q.delete(); got_q.delete();
    end else begin
      if (req_rdy !== exp_rdy) arb_bad <= arb_bad + 1;
      if ($countones(res_val) > 1) oh_bad <= oh_bad + 1;
      if ((exp_rdy & req_val) != 0) begin
        exp_q.push_back('{cyc, lane_of(exp_rdy), req_data[lane_of(exp_rdy)*W +: W]});
        m_last <= lane_of(exp_rdy);
        m_lane <= lane_of(exp_rdy);
        m_lock <= !req_last[lane_of(exp_rdy)];
      end
      if ((res_val & res_rdy) != 0) got_q.push_back('{cyc, lane_of(res_val), res_data});
    end
  end

  task automatic reset_dut();
    @(posedge clk); #1;
    rst = 1'b1; req_val = '0; req_last = '0; res_rdy = '1; inj = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain(output bit ok);
    int g = 0;
    req_last = '1; res_rdy = '1;
    while (m_lock && g < 50) begin
      req_val = '0; req_val[m_lane] = 1'b1;
      @(posedge clk); #1; g++;
    end
    req_val = '0;
    while (busy && g < 200) begin @(posedge clk); #1; g++; end
    ok = !busy;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_rdy !== '0) begin n_fail++; $display("FAIL reset_req_rdy: got %b want 0", req_rdy); end
    n_checks++; if (unit_op_val !== 1'b0 || unit_op_data !== '0) begin n_fail++; $display("FAIL reset_op: got %b/%h want 0/0", unit_op_val, unit_op_data); end
    n_checks++; if (res_val !== '0 || busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL reset_flags: res_val=%b busy=%b err=%b want 0", res_val, busy, err); end
    @(posedge clk); #1;
    rst = 1'b0; req_val = '1; req_last = '1;
    @(negedge clk);
    n_checks++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL reset_first_grant: got %b want 0001", req_rdy); end
    @(posedge clk); #1; req_val = '0;
  endtask

  task automatic test_single();
    int k = 0; bit found = 0;
    reset_dut();
    req_val = 4'b0100; req_last = 4'b0100; req_data[2*W +: W] = 16'h0100;
    @(negedge clk);
    n_checks++; if (req_rdy !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", req_rdy); end
    @(posedge clk); #1; req_val = '0;
    @(negedge clk);
    n_checks++; if (unit_op_val !== 1'b1 || unit_op_data !== 16'h0100) begin n_fail++; $display("FAIL single_op: got %b/%h want 1/0100", unit_op_val, unit_op_data); end
    while (!found && k < 20) begin
      @(posedge clk); k++; @(negedge clk);
      if (res_val != 0) found = 1;
    end
    n_checks++; if (!found || k != 6) begin n_fail++; $display("FAIL single_latency: got %0d cycles (found=%0b) want 6", k, found); end
    n_checks++; if (res_val !== 4'b0100 || res_data !== fn(16'h0100)) begin n_fail++; $display("FAIL single_result: got %b/%h want 0100/%h", res_val, res_data, fn(16'h0100)); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_hi: got %b want 1", busy); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || res_val !== '0) begin n_fail++; $display("FAIL single_busy_lo: busy=%b res_val=%b want 0", busy, res_val); end
  endtask

  task automatic test_round_robin();
    int exp_lanes[6] = '{0, 1, 3, 0, 1, 3};
    int base = arb_bad; bit ok;
    reset_dut();
    req_val = 4'b1011; req_last = '1;
    for (int i = 0; i < 6; i++) begin
      req_data = {$urandom, $urandom};
      @(posedge clk); #1;
    end
    req_val = '0;
    drain(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rr_drain: busy stuck, got 1 want 0"); end
    n_checks++; if (exp_q.size() != 6 || got_q.size() != 6) begin n_fail++; $display("FAIL rr_count: got acc=%0d res=%0d want 6/6", exp_q.size(), got_q.size()); end
    for (int i = 0; i < 6 && i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (exp_q[i].lane != exp_lanes[i] || exp_q[i].cyc != exp_q[0].cyc + i || got_q[i].lane != exp_lanes[i] || got_q[i].data !== fn(exp_q[i].data))
        begin n_fail++; $display("FAIL rr_beat%0d: got lane %0d/%0d data %h want lane %0d data %h", i, exp_q[i].lane, got_q[i].lane, got_q[i].data, exp_lanes[i], fn(exp_q[i].data)); end
    end
    n_checks++; if (arb_bad != base) begin n_fail++; $display("FAIL rr_arb: got %0d rdy mismatches want 0", arb_bad - base); end
  endtask

  task automatic test_packet_lock();
    logic v1[7] = '{1, 1, 0, 1, 1, 0, 0};
    logic v0[7] = '{0, 1, 1, 1, 1, 1, 1};
    logic l1[7] = '{0, 0, 0, 0, 1, 0, 0};
    int exp_lanes[6] = '{1, 1, 1, 1, 0, 0};
    bit ok;
    reset_dut();
    for (int c = 0; c < 7; c++) begin
      req_val = {1'b0, 1'b0, v1[c], v0[c]}; req_last = {2'b00, l1[c], 1'b1};
      req_data = {$urandom, $urandom};
      @(negedge clk);
      if (c == 2) begin
        n_checks++; if (req_rdy !== 4'b0010) begin n_fail++; $display("FAIL lock_gap_rdy: got %b want 0010", req_rdy); end
      end
      @(posedge clk); #1;
    end
    req_val = '0;
    drain(ok);
    n_checks++; if (!ok || exp_q.size() != 6 || got_q.size() != 6) begin n_fail++; $display("FAIL lock_count: got acc=%0d res=%0d drained=%0b want 6/6/1", exp_q.size(), got_q.size(), ok); end
    for (int i = 0; i < 6 && i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (exp_q[i].lane != exp_lanes[i] || got_q[i].lane != exp_lanes[i] || got_q[i].data !== fn(exp_q[i].data))
        begin n_fail++; $display("FAIL lock_beat%0d: got lane %0d data %h want lane %0d data %h", i, got_q[i].lane, got_q[i].data, exp_lanes[i], fn(exp_q[i].data)); end
    end
    if (exp_q.size() >= 5) begin
      n_checks++; if (exp_q[4].cyc != exp_q[3].cyc + 1) begin n_fail++; $display("FAIL lock_release: lane0 at cycle %0d want %0d", exp_q[4].cyc, exp_q[3].cyc + 1); end
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    reset_dut();
    fork
      begin
        int n = 0, g = 0;
        req_val = 4'b1000; req_last = '1; req_data = {$urandom, $urandom};
        while (n < 8 && g < 200) begin
          @(negedge clk); if (req_rdy[3]) n++;
          @(posedge clk); #1; g++;
          if (n == 8) req_val = '0; else req_data = {$urandom, $urandom};
        end
        req_val = '0;
      end
      begin
        int w = 0;
        do begin @(negedge clk); w++; end while (!res_val[3] && w < 40);
        n_checks++;
        if (!res_val[3]) begin n_fail++; $display("FAIL bp_first_result: got none in %0d cycles want 1", w); end
        else begin
          @(posedge clk); #1; res_rdy[3] = 1'b0;
          for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (unit_clk_en !== 1'b0 || res_val !== 4'b1000) begin n_fail++; $display("FAIL bp_stall%0d: clk_en=%b res_val=%b want 0/1000", i, unit_clk_en, res_val); end
            n_checks++; if (exp_q.size() < 2 || res_data !== fn(exp_q[1].data)) begin n_fail++; $display("FAIL bp_hold%0d: got %h want 2nd beat result", i, res_data); end
            @(posedge clk);
          end
          #1; res_rdy[3] = 1'b1;
        end
      end
    join
    drain(ok);
    n_checks++; if (!ok || exp_q.size() != 8 || got_q.size() != 8) begin n_fail++; $display("FAIL bp_count: got acc=%0d res=%0d drained=%0b want 8/8/1", exp_q.size(), got_q.size(), ok); end
    for (int i = 0; i < 8 && i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i].lane != 3 || got_q[i].data !== fn(exp_q[i].data))
        begin n_fail++; $display("FAIL bp_beat%0d: got lane %0d data %h want lane 3 data %h", i, got_q[i].lane, got_q[i].data, fn(exp_q[i].data)); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    reset_dut();
    req_val = 4'b0100; req_last = '0;
    for (int i = 0; i < 3; i++) begin req_data = {$urandom, $urandom}; @(posedge clk); #1; end
    req_val = '0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rmid_busy_before: got %b want 1", busy); end
    @(posedge clk); #1;
    rst = 1'b1; req_val = 4'b1101; req_last = 4'b1001;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    n_checks++; if (res_val !== '0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_cleared: res_val=%b busy=%b want 0/0", res_val, busy); end
    n_checks++; if (req_rdy !== 4'b0001) begin n_fail++; $display("FAIL rmid_grant: got %b want 0001", req_rdy); end
    @(posedge clk); #1; req_val = '0;
    drain(ok);
    n_checks++; if (!ok || got_q.size() != 1 || (got_q.size() == 1 && got_q[0].lane != 0)) begin n_fail++; $display("FAIL rmid_results: got %0d results drained=%0b want exactly one from lane 0", got_q.size(), ok); end
  endtask

  task automatic test_err();
    reset_dut();
    inj = 1'b1;
    @(negedge clk);
    n_checks++; if (res_val !== '0) begin n_fail++; $display("FAIL err_resval: got %b want 0", res_val); end
    @(posedge clk); #1; inj = 1'b0;
    @(negedge clk);
    n_checks++; if (err !== ERR_EXP) begin n_fail++; $display("FAIL err_set: got %b want %b", err, ERR_EXP); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (err !== ERR_EXP) begin n_fail++; $display("FAIL err_sticky: got %b want %b", err, ERR_EXP); end
    reset_dut();
    @(negedge clk);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
  endtask

  task automatic test_random();
    int base = arb_bad; bit ok;
    reset_dut();
    for (int c = 0; c < 400; c++) begin
      req_val  = N'($urandom);
      req_last = N'($urandom) | N'($urandom);
      req_data = {$urandom, $urandom};
      res_rdy  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      @(posedge clk); #1;
    end
    drain(ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL rand_drain: busy stuck, got 1 want 0"); end
    n_checks++; if (got_q.size() != exp_q.size() || exp_q.size() < 50) begin n_fail++; $display("FAIL rand_count: got res=%0d acc=%0d want equal and >=50", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i].lane != exp_q[i].lane || got_q[i].data !== fn(exp_q[i].data))
        begin n_fail++; $display("FAIL rand_beat%0d: got lane %0d data %h want lane %0d data %h", i, got_q[i].lane, got_q[i].data, exp_q[i].lane, fn(exp_q[i].data)); end
    end
    n_checks++; if (arb_bad != base) begin n_fail++; $display("FAIL rand_arb: got %0d rdy mismatches want 0", arb_bad - base); end
    n_checks++; if (oh_bad != 0) begin n_fail++; $display("FAIL res_onehot: got %0d multi-hot cycles want 0", oh_bad); end
  endtask

  initial begin
    rst = 1'b1; req_val = '0; req_last = '0; req_data = '0; res_rdy = '1; inj = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_back_pressure();
    test_reset_mid();
    test_err();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
